// File: rtl/fix_trailer_check.sv
// fix_trailer_check
// Frames FIX messages on the inbound byte stream ("8=" ... "10=ddd<SOH>"),
// accumulates the modulo-256 byte sum up to the SOH that precedes "10=",
// decodes the three trailer digits and reports pass/fail with a one-cycle
// done_o pulse. Result outputs hold until the next report.
//
// Optional feature: define FIX_LEN_LIMIT_EN to bound message length to
// MAX_LEN bytes; an overlong message is reported with err_code_o = 3.
//
// state  | meaning
// -------+---------------------------------------------------------------
// S_IDLE | hunting for '8' (0x38) that opens a header
// S_HDR  | '8' seen, expecting '=' (0x3D); anything else silently aborts
// S_BODY | summing body bytes, watching for <SOH>"10=" to enter trailer
// S_TRL  | accumulating trailer digits until the closing SOH

module fix_trailer_check #(
    parameter int MAX_LEN = 4096
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data_i,
    input  logic       valid_i,
    output logic       done_o,
    output logic       ok_o,
    output logic [1:0] err_code_o,
    output logic [7:0] computed_o,
    output logic [9:0] received_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HDR  = 2'd1,
        S_BODY = 2'd2,
        S_TRL  = 2'd3
    } state_t;

    localparam logic [7:0] CH_8   = 8'h38;
    localparam logic [7:0] CH_EQ  = 8'h3D;
    localparam logic [7:0] CH_1   = 8'h31;
    localparam logic [7:0] CH_0   = 8'h30;
    localparam logic [7:0] CH_SOH = 8'h01;

    localparam logic [1:0] ERR_NONE   = 2'd0;
    localparam logic [1:0] ERR_MISM   = 2'd1;
    localparam logic [1:0] ERR_FORMAT = 2'd2;
    localparam logic [1:0] ERR_LONG   = 2'd3;

    state_t     state, state_n;
    logic [7:0] sum, sum_n;
    logic [7:0] snap, snap_n;
    logic [9:0] val, val_n;
    logic [1:0] match, match_n;
    logic [1:0] digits, digits_n;

    // report strobe and the values it loads into the result registers
    logic       rep;
    logic       rep_ok;
    logic [1:0] rep_err;
    logic [7:0] rep_comp;
    logic [9:0] rep_rcv;

    logic       is_digit;
    logic [7:0] sum_add;
    logic [9:0] val_next;

    assign is_digit = (data_i >= 8'h30) && (data_i <= 8'h39);
    assign sum_add  = sum + data_i;
    assign val_next = (val << 3) + (val << 1) + {6'd0, data_i[3:0]};

`ifdef FIX_LEN_LIMIT_EN
    localparam int LEN_W = $clog2(MAX_LEN + 1);

    logic [LEN_W-1:0] len, len_n;
    logic             len_full;

    // the byte now on data_i would push the message past MAX_LEN
    assign len_full = (len == LEN_W'(MAX_LEN));

    // length counter register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            len <= '0;
        end else begin
            len <= len_n;
        end
    end
`else
    logic len_full;
    logic unused_max_len;

    assign len_full       = 1'b0;
    assign unused_max_len = ^MAX_LEN;
`endif

    // state and datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= S_IDLE;
            sum    <= 8'd0;
            snap   <= 8'd0;
            val    <= 10'd0;
            match  <= 2'd0;
            digits <= 2'd0;
        end else begin
            state  <= state_n;
            sum    <= sum_n;
            snap   <= snap_n;
            val    <= val_n;
            match  <= match_n;
            digits <= digits_n;
        end
    end

    // next-state, datapath update and report decision
    always_comb begin
        state_n  = state;
        sum_n    = sum;
        snap_n   = snap;
        val_n    = val;
        match_n  = match;
        digits_n = digits;
`ifdef FIX_LEN_LIMIT_EN
        len_n    = len;
`endif
        rep      = 1'b0;
        rep_ok   = 1'b0;
        rep_err  = ERR_NONE;
        rep_comp = snap;
        rep_rcv  = val;

        if (valid_i) begin
            case (state)
                S_IDLE: begin
                    if (data_i == CH_8) begin
                        state_n  = S_HDR;
                        sum_n    = CH_8;
                        snap_n   = 8'd0;
                        val_n    = 10'd0;
                        match_n  = 2'd0;
                        digits_n = 2'd0;
`ifdef FIX_LEN_LIMIT_EN
                        len_n    = LEN_W'(1);
`endif
                    end
                end

                S_HDR: begin
                    if (data_i == CH_EQ) begin
                        state_n = S_BODY;
                        sum_n   = sum_add;
`ifdef FIX_LEN_LIMIT_EN
                        len_n   = LEN_W'(2);
`endif
                    end else begin
                        state_n = S_IDLE;
                    end
                end

                S_BODY: begin
                    if (len_full) begin
                        rep      = 1'b1;
                        rep_err  = ERR_LONG;
                        rep_comp = sum;
                    end else begin
                        sum_n = sum_add;
`ifdef FIX_LEN_LIMIT_EN
                        len_n = len + LEN_W'(1);
`endif
                        if (data_i == CH_SOH) begin
                            snap_n  = sum_add;
                            match_n = 2'd1;
                        end else if (match == 2'd1 && data_i == CH_1) begin
                            match_n = 2'd2;
                        end else if (match == 2'd2 && data_i == CH_0) begin
                            match_n = 2'd3;
                        end else if (match == 2'd3 && data_i == CH_EQ) begin
                            state_n  = S_TRL;
                            match_n  = 2'd0;
                            digits_n = 2'd0;
                            val_n    = 10'd0;
                        end else begin
                            match_n = 2'd0;
                        end
                    end
                end

                S_TRL: begin
                    if (len_full) begin
                        rep      = 1'b1;
                        rep_err  = ERR_LONG;
                        rep_comp = sum;
                    end else begin
                        sum_n = sum_add;
`ifdef FIX_LEN_LIMIT_EN
                        len_n = len + LEN_W'(1);
`endif
                        if (is_digit && digits != 2'd3) begin
                            val_n    = val_next;
                            digits_n = digits + 2'd1;
                        end else if (data_i == CH_SOH && digits == 2'd3) begin
                            rep     = 1'b1;
                            rep_ok  = (val == {2'b00, snap});
                            rep_err = rep_ok ? ERR_NONE : ERR_MISM;
                        end else begin
                            // non-digit, early SOH, or a 4th digit
                            rep     = 1'b1;
                            rep_err = ERR_FORMAT;
                        end
                    end
                end

                default: state_n = S_IDLE;
            endcase

            // every report returns to a clean IDLE so the next '8' can start at once
            if (rep) begin
                state_n  = S_IDLE;
                sum_n    = 8'd0;
                snap_n   = 8'd0;
                val_n    = 10'd0;
                match_n  = 2'd0;
                digits_n = 2'd0;
`ifdef FIX_LEN_LIMIT_EN
                len_n    = '0;
`endif
            end
        end
    end

    // result registers: done_o pulses, the rest hold until the next report
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            done_o     <= 1'b0;
            ok_o       <= 1'b0;
            err_code_o <= 2'd0;
            computed_o <= 8'd0;
            received_o <= 10'd0;
        end else begin
            done_o <= rep;
            if (rep) begin
                ok_o       <= rep_ok;
                err_code_o <= rep_err;
                computed_o <= rep_comp;
                received_o <= rep_rcv;
            end
        end
    end

endmodule

// File: tb/tb_fix_trailer_check.sv
// Bench for fix_trailer_check: expected reports are queued as each
// terminating byte is driven and compared when done_o pulses.

module tb_fix_trailer_check;

    logic       clk;
    logic       rst;
    logic [7:0] data_i;
    logic       valid_i;
    logic       done_o;
    logic       ok_o;
    logic [1:0] err_code_o;
    logic [7:0] computed_o;
    logic [9:0] received_o;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        int cyc;
        int ok;
        int err;
        int comp;
        int rcv;
        bit chk_rcv;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] body_q[$];
    logic [7:0] trl_q[$];

    fix_trailer_check #(.MAX_LEN(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .data_i    (data_i),
        .valid_i   (valid_i),
        .done_o    (done_o),
        .ok_o      (ok_o),
        .err_code_o(err_code_o),
        .computed_o(computed_o),
        .received_o(received_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            valid_i = 1'b0;
        end
    endtask

    task automatic drive(input logic [7:0] b);
        @(posedge clk);
        #1;
        data_i  = b;
        valid_i = 1'b1;
    endtask

    task automatic push_exp(input int ok, input int err, input int comp, input int rcv, input bit chk_rcv);
        exp_t e;
        e.cyc     = cyc + 1;
        e.ok      = ok;
        e.err     = err;
        e.comp    = comp;
        e.rcv     = rcv;
        e.chk_rcv = chk_rcv;
        exp_q.push_back(e);
    endtask

    // sends "8=" body_q <SOH> "10=" trl_q; the last trailer byte terminates
    task automatic send_fix(input bit gap, input int exp_err, input int exp_rcv);
        logic [7:0] msg[$];
        int s;
        msg = {8'h38, 8'h3D};
        foreach (body_q[i]) msg.push_back(body_q[i]);
        msg.push_back(8'h01);
        s = 8'h38 + 8'h3D + 8'h01;
        foreach (body_q[i]) s += body_q[i];
        s = s % 256;
        msg.push_back(8'h31);
        msg.push_back(8'h30);
        msg.push_back(8'h3D);
        foreach (trl_q[i]) msg.push_back(trl_q[i]);
        for (int i = 0; i < msg.size(); i++) begin
            if (gap && i > 0) idle(1);
            drive(msg[i]);
            if (i == msg.size() - 1)
                push_exp((exp_err == 0) ? 1 : 0, exp_err, s, exp_rcv, 1'b1);
        end
    endtask

    // compare each report against the head of the scoreboard
    always @(negedge clk) begin
        if (rst && done_o) begin
            check("done_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                exp_t e;
                e = exp_q.pop_front();
                check("done_cycle", 32'(cyc), 32'(e.cyc));
                check("ok", 32'(ok_o), 32'(e.ok));
                check("err_code", 32'(err_code_o), 32'(e.err));
                check("computed", 32'(computed_o), 32'(e.comp));
                if (e.chk_rcv) check("received", 32'(received_o), 32'(e.rcv));
            end
        end
    end

    task automatic check_zero(input string tag);
        check({tag, "_done"}, 32'(done_o), 32'd0);
        check({tag, "_ok"}, 32'(ok_o), 32'd0);
        check({tag, "_err"}, 32'(err_code_o), 32'd0);
        check({tag, "_computed"}, 32'(computed_o), 32'd0);
        check({tag, "_received"}, 32'(received_o), 32'd0);
    endtask

    initial begin
        rst     = 1'b0;
        valid_i = 1'b0;
        data_i  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        rst = 1'b1;
        idle(2);

        // pass: sum 183
        body_q = {8'h41};
        trl_q  = {8'h31, 8'h38, 8'h33, 8'h01};
        send_fix(1'b0, 0, 183);
        idle(2);

        // mismatch
        trl_q = {8'h31, 8'h38, 8'h34, 8'h01};
        send_fix(1'b0, 1, 184);
        idle(2);

        // wrap: 378 mod 256 = 122
        body_q = {8'h41, 8'h41, 8'h41, 8'h41};
        trl_q  = {8'h31, 8'h32, 8'h32, 8'h01};
        send_fix(1'b0, 0, 122);
        idle(2);

        // format error on 'x', then a pass message starting the very next cycle
        body_q = {8'h41};
        trl_q  = {8'h31, 8'h78};
        send_fix(1'b0, 2, 1);
        trl_q  = {8'h31, 8'h38, 8'h33, 8'h01};
        send_fix(1'b0, 0, 183);
        idle(2);

        // stall every other byte with a "110=" body field; 183+207 mod 256 = 134
        body_q = {8'h41, 8'h31, 8'h31, 8'h30, 8'h3D};
        trl_q  = {8'h31, 8'h33, 8'h34, 8'h01};
        send_fix(1'b1, 0, 134);
        body_q = {8'h41};
        trl_q  = {8'h31, 8'h38, 8'h33, 8'h01};
        send_fix(1'b0, 0, 183);
        idle(3);

        // value above 255 always mismatches
        trl_q = {8'h39, 8'h30, 8'h30, 8'h01};
        send_fix(1'b0, 1, 900);
        idle(1);

        // SOH after only two digits
        trl_q = {8'h31, 8'h38, 8'h01};
        send_fix(1'b0, 2, 18);
        idle(1);

        // fourth digit
        trl_q = {8'h31, 8'h38, 8'h33, 8'h30};
        send_fix(1'b0, 2, 183);
        idle(2);

`ifdef FIX_LEN_LIMIT_EN
        // 17th byte exceeds MAX_LEN=16; sum of first 16 bytes = 1027 mod 256 = 3
        drive(8'h38);
        drive(8'h3D);
        for (int i = 0; i < 15; i++) begin
            drive(8'h41);
            if (i == 14) push_exp(0, 3, 3, 0, 1'b0);
        end
        idle(2);
`endif

        // reset mid-body: no report, outputs cleared
        drive(8'h38);
        drive(8'h3D);
        drive(8'h41);
        drive(8'h41);
        idle(1);
        #2;
        rst = 1'b0;
        #1;
        check_zero("midreset");
        idle(2);
        rst = 1'b1;
        idle(1);

        // recovery after reset
        body_q = {8'h41};
        trl_q  = {8'h31, 8'h38, 8'h33, 8'h01};
        send_fix(1'b0, 0, 183);
        idle(2);

        for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge clk);
        check("pending_reports", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fix_trailer_check.md
# fix_trailer_check

- Validates the checksum trailer of each FIX message on the inbound byte stream and reports the result.
- Frames each message itself: start is the header `8=`; end is the SOH after the `10=` value.
- Computes the modulo-256 byte sum over header through the SOH preceding `10=`.
- Parses the three ASCII digits of tag 10 and compares them with the computed sum; sits directly downstream of the byte receiver, in parallel with the checksum block.

## Interface
- `MAX_LEN`, 4096: maximum message length in bytes, `8` through final SOH inclusive; used only when `FIX_LEN_LIMIT_EN` is defined.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `data_i` input 8: received byte.
- `valid_i` input 1: `data_i` valid this cycle; when low, no state change.
- `done_o` output 1: one-cycle pulse; result outputs updated.
- `ok_o` output 1: last message passed; holds until next `done_o`.
- `err_code_o` output 2: 0 none, 1 mismatch, 2 trailer format, 3 overlength; holds until next `done_o`.
- `computed_o` output 8: sum at SOH before `10=`; holds until next `done_o`.
- `received_o` output 10: decoded tag-10 value, 0..999; holds until next `done_o`.

## Operation
Rules below apply only to bytes with `valid_i`=1.

- **IDLE**
  - `0x38` → HDR, sum=0x38, len=1.
  - Any other byte: stay in IDLE.
- **HDR**
  - `0x3D` → BODY, sum+=0x3D, len=2.
  - Any other byte → IDLE, no report.
- **BODY**
  - Every byte: sum+=byte (8-bit wrap), len+=1.
  - On SOH (0x01): snap=sum including the SOH; match=1.
  - Match sequence: match=1 and `0x31` → 2; match=2 and `0x30` → 3; match=3 and `0x3D` → TRL, digits=0, val=0.
  - Any other byte resets match to 0, or to 1 if the byte is SOH.
  - Bytes of the `10=` tag are added to sum but never to snap.
- **TRL**
  - ASCII digit: val=val*10+(byte−0x30), digits+=1.
  - SOH with digits==3 → report, then IDLE.
  - Report: ok = (val==snap); err 0 if ok, else 1.
  - Non-digit, SOH with digits≠3, or a 4th digit → report err 2, then IDLE.
- **Reporting**
  - The report loads `computed_o`=snap and `received_o`=val.
  - For err 2, `received_o` is the partial val.
  - A message aborted in HDR produces no report.

## Timing
- **Reset:** state IDLE, sum/snap/len/val/match/digits 0, and all outputs 0 (`done_o`, `ok_o`, `err_code_o`, `computed_o`, `received_o`).
- **Report latency:** result outputs and `done_o` are registered.
  - `done_o` is high exactly one cycle, the cycle after the terminating or offending byte is sampled.
  - Other outputs change in that same cycle.
- **Back-to-back:** the FSM is in IDLE on the cycle after the terminating byte, so a `0x38` there starts a new message. That byte may coincide with `done_o`; both proceed.
- **Stall:** `valid_i` gaps of any length do not alter state or results.
- **Reset mid-message:** immediate abort to reset values with no `done_o`; the partial message is discarded.
- **Value range:** `received_o` is 10 bits, no overflow for 3 digits. Values 256..999 always mismatch (err 1).

## Configuration
- **`FIX_LEN_LIMIT_EN` defined:**
  - A byte that would make len exceed `MAX_LEN` while in BODY or TRL causes a report with err 3, then IDLE.
  - That byte is otherwise ignored; `computed_o` is the current sum.
  - len counter width is $clog2(MAX_LEN+1).
- **Undefined:** no len counter, err 3 is never produced, and messages are unbounded.

## Test plan
- **Pass:** 38 3D 41 01 31 30 3D 31 38 33 01 → `done_o` one cycle after last byte; `ok_o`=1, err 0, `computed_o`=183, `received_o`=183.
- **Mismatch:** same stream with digits 31 38 34 → `ok_o`=0, err 1, `computed_o`=183, `received_o`=184.
- **Wrap:** 38 3D 41 41 41 41 01 31 30 3D 31 32 32 01 → sum 378 mod 256; `computed_o`=122, `ok_o`=1.
- **Format:** pass stream with digits 31 78 → `done_o` after the 0x78 byte; err 2, `received_o`=1. Next byte 0x38 starts a new message.
- **Stall and false tag:** pass stream with `valid_i` low every other cycle, plus body field `110=` (31 31 30 3D) inserted before the SOH.
  - The `110=` field must not trigger TRL; the result is unchanged apart from its bytes' sum contribution.
  - Back-to-back: a second message starts the cycle after the terminating SOH.
- **Overlength and reset:** `FIX_LEN_LIMIT_EN`, `MAX_LEN`=16; send 38 3D + 15×0x41.
  - Expected: err 3 reported after the 17th byte.
  - Repeat, asserting `rst`=0 mid-body: no `done_o`, and all outputs read 0.
